// File: rtl/fetch_unit.sv
// fetch_unit: 2-wide fetch stage; one aligned 64-bit line request in flight, unpacked into two IF_IB_PACKET slots.
// Optional macro FETCH_PERF_CNT_EN adds saturating counters perf_lines / perf_stall_cyc / perf_squash.

`ifndef NOP
`define NOP 32'h0000_0013
`endif

module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                buffer_full,
    input  logic                                squashed_sig_rob,
    input  logic [ADDR_W-1:0]                   squash_pc,
    output logic                                mem_req,
    output logic [ADDR_W-1:0]                   mem_addr,
    input  logic                                mem_gnt,
    input  logic                                mem_rsp_valid,
    input  logic [63:0]                         mem_rsp_data,
    // Each slot is packed as {valid, inst[31:0], pc[ADDR_W-1:0], npc[ADDR_W-1:0]}.
    output logic [1:0][2*ADDR_W+32:0]           if_ib_packet
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_lines,
    output logic [31:0]                         perf_stall_cyc,
    output logic [31:0]                         perf_squash
`endif
);

    localparam logic [ADDR_W-1:0] STEP4 = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] STEP8 = ADDR_W'(32'd8);

    typedef struct packed {
        logic              valid;
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] npc;
    } pkt_t;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic pkt_t idle_slot();
        pkt_t p;
        p.valid = 1'b0;
        p.inst  = `NOP;
        p.pc    = {ADDR_W{1'b0}};
        p.npc   = {ADDR_W{1'b0}};
        return p;
    endfunction

    function automatic pkt_t live_slot(input logic [31:0] inst, input logic [ADDR_W-1:0] pc);
        pkt_t p;
        p.valid = 1'b1;
        p.inst  = inst;
        p.pc    = pc;
        p.npc   = pc + STEP4;
        return p;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [63:0]       hold_q, hold_d;
    logic              deliver_s;
    logic [63:0]       line_s;
    logic [ADDR_W-1:0] pc_adv_s;
    pkt_t              slot0_s, slot1_s;

    // A line starting at the upper word only yields one instruction.
    assign pc_adv_s = pc_q + (pc_q[2] ? STEP4 : STEP8);

    // State, fetch PC and hold register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic; a squash overrides everything and picks REQ or DRAIN by whether a response is still owed.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        deliver_s = 1'b0;
        line_s    = mem_rsp_data;
        if (squashed_sig_rob) begin
            pc_d   = squash_pc;
            hold_d = 64'd0;
            case (state_q)
                S_REQ:   state_d = mem_gnt ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = mem_rsp_valid ? S_REQ : S_DRAIN;
                S_HOLD:  state_d = S_REQ;
                S_DRAIN: state_d = mem_rsp_valid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (mem_gnt) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid && !buffer_full) begin
                        deliver_s = 1'b1;
                        pc_d      = pc_adv_s;
                        state_d   = S_REQ;
                    end else if (mem_rsp_valid) begin
                        hold_d  = mem_rsp_data;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!buffer_full) begin
                        deliver_s = 1'b1;
                        line_s    = hold_q;
                        hold_d    = 64'd0;
                        pc_d      = pc_adv_s;
                        state_d   = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (mem_rsp_valid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Line unpack into the two buffer slots.
    always_comb begin
        slot0_s = idle_slot();
        slot1_s = idle_slot();
        if (deliver_s) begin
            if (pc_q[2]) begin
                slot0_s = live_slot(line_s[63:32], pc_q);
            end else begin
                slot0_s = live_slot(line_s[31:0], pc_q);
                slot1_s = live_slot(line_s[63:32], pc_q + STEP4);
            end
        end else begin
            slot0_s = idle_slot();
            slot1_s = idle_slot();
        end
    end

    assign mem_req         = (state_q == S_REQ) & ~reset;
    assign mem_addr        = {pc_q[ADDR_W-1:3], 3'b000};
    assign if_ib_packet[0] = slot0_s;
    assign if_ib_packet[1] = slot1_s;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_lines_q, perf_stall_q, perf_squash_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_lines_q  <= 32'd0;
            perf_stall_q  <= 32'd0;
            perf_squash_q <= 32'd0;
        end else begin
            perf_lines_q  <= sat_inc(perf_lines_q, deliver_s);
            perf_stall_q  <= sat_inc(perf_stall_q, state_q == S_HOLD);
            perf_squash_q <= sat_inc(perf_squash_q, squashed_sig_rob);
        end
    end

    assign perf_lines     = perf_lines_q;
    assign perf_stall_cyc = perf_stall_q;
    assign perf_squash    = perf_squash_q;
`endif

endmodule
